// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, synchronous imem interface with a
// one-entry hold register for stalls, and two-cycle redirect bubbles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0100_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        kill_out,
  output logic        valid_out
);

  logic [31:0] pc_req;
  logic [31:0] pc_resp;
  logic        resp_valid;
  logic [31:0] hold_instr;
  logic        hold_valid;
  logic [31:0] target_pc;
  logic        capture;

  // Targets are word aligned; the low two bits of redirect_pc are dropped.
  assign target_pc = {redirect_pc[31:2], 2'b00};

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = &redirect_pc[1:0];

  // Capture only correct-path data, and only once per stall.
  assign capture = !reset && !redirect && stall && resp_valid && !hold_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_req     <= RESET_PC;
      pc_resp    <= '0;
      resp_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (redirect) begin
      pc_req     <= target_pc;
      resp_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (stall) begin
      if (capture) hold_valid <= 1'b1;
    end else begin
      pc_resp    <= pc_req;
      pc_req     <= pc_req + 32'd4;
      resp_valid <= 1'b1;
      hold_valid <= 1'b0;
    end
  end

  // NOTE: the hold data register has no reset; hold_valid alone guards it,
  // so its power-up contents can never reach instr_out.
  always_ff @(posedge clock) begin
    if (capture) hold_instr <= imem_rdata;
  end

  // NOTE: every output gets a default first so always_comb infers no latch.
  always_comb begin
    kill_out  = reset | redirect | ~resp_valid;
    valid_out = ~kill_out;
    pc_out    = pc_resp;
    imem_addr = pc_req;
    instr_out = imem_rdata;
    if (kill_out)        instr_out = NOP_INSTR;
    else if (hold_valid) instr_out = hold_instr;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a synchronous memory whose
// contents are mem[a] = a ^ 32'hA5A5A5A5.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0100_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] PAT    = 32'hA5A5_A5A5;

  logic        clock = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic [31:0] pc_out, instr_out;
  logic        kill_out, valid_out;

  int tests = 0;
  int fails = 0;

  fetch_stage dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .kill_out   (kill_out),
    .valid_out  (valid_out)
  );

  always #5 clock = ~clock;

  // One-cycle-latency instruction memory.
  always @(posedge clock) imem_rdata <= imem_addr ^ PAT;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ PAT;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic expect_pair(input string tag, input logic [31:0] pc);
    #1;
    check({tag, " kill"},  {31'd0, kill_out},  32'd0);
    check({tag, " valid"}, {31'd0, valid_out}, 32'd1);
    check({tag, " pc"},    pc_out,             pc);
    check({tag, " instr"}, instr_out,          mem(pc));
  endtask

  task automatic expect_bubble(input string tag);
    #1;
    check({tag, " kill"},  {31'd0, kill_out},  32'd1);
    check({tag, " valid"}, {31'd0, valid_out}, 32'd0);
    check({tag, " instr"}, instr_out,          NOP);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    expect_bubble("in_reset");

    // Reset state, then free run.
    reset = 1'b0;
    expect_bubble("post_reset");
    check("post_reset addr", imem_addr, RST_PC);
    check("post_reset pc",   pc_out,    32'd0);
    tick(); expect_pair("run0", RST_PC);
    check("run0 addr", imem_addr, RST_PC + 32'd4);
    tick(); expect_pair("run1", RST_PC + 32'd4);
    tick();

    // Stall three cycles while presenting 0x01000008.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_pair("stall", 32'h0100_0008);
      check("stall addr", imem_addr, 32'h0100_000C);
      tick();
    end
    stall = 1'b0;
    expect_pair("release", 32'h0100_0008);
    check("release addr", imem_addr, 32'h0100_000C);
    tick(); expect_pair("after_release", 32'h0100_000C);
    tick(); expect_pair("pre_redirect", 32'h0100_0010);

    // Redirect to a misaligned target.
    redirect = 1'b1; redirect_pc = 32'h0200_0002;
    expect_bubble("redir_r0");
    tick(); redirect = 1'b0;
    expect_bubble("redir_r1");
    check("redir_r1 addr", imem_addr, 32'h0200_0000);
    tick(); expect_pair("redir_tgt", 32'h0200_0000);
    tick(); expect_pair("redir_tgt4", 32'h0200_0004);

    // Redirect together with stall, stall held two more cycles.
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0300_0000;
    expect_bubble("rs_r0");
    tick(); redirect = 1'b0;
    expect_bubble("rs_stall1");
    tick(); expect_bubble("rs_stall2");
    check("rs_stall2 addr", imem_addr, 32'h0300_0000);
    tick(); stall = 1'b0;
    expect_bubble("rs_release");
    tick(); expect_pair("rs_tgt", 32'h0300_0000);

    // PC wrap.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(); redirect = 1'b0;
    expect_bubble("wrap_r1");
    tick(); expect_pair("wrap0", 32'hFFFF_FFF8);
    tick(); expect_pair("wrap1", 32'hFFFF_FFFC);
    tick(); expect_pair("wrap2", 32'h0000_0000);
    check("wrap2 addr", imem_addr, 32'h0000_0004);

    // Second redirect during the bubble of the first: newest wins.
    redirect = 1'b1; redirect_pc = 32'h0400_0000;
    tick(); redirect_pc = 32'h0500_0000;
    expect_bubble("rr_r1");
    tick(); redirect = 1'b0;
    expect_bubble("rr_r2");
    check("rr_r2 addr", imem_addr, 32'h0500_0000);
    tick(); expect_pair("rr_tgt", 32'h0500_0000);

    // Reset during a stall with the hold register full.
    stall = 1'b1;
    tick(); expect_pair("hold_full", 32'h0500_0000);
    reset = 1'b1;
    expect_bubble("mid_reset");
    tick(); reset = 1'b0;
    expect_bubble("mr_post");
    check("mr_post addr", imem_addr, RST_PC);
    check("mr_post pc",   pc_out,    32'd0);
    tick(); expect_bubble("mr_stall");
    stall = 1'b0;
    expect_bubble("mr_release");
    tick(); expect_pair("mr_first", RST_PC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RV32 pipeline. Generates the PC, drives a synchronous instruction memory with one-cycle read latency, and presents each fetched {pc, instruction} pair to the IF/ID pipeline register. Also drives that register's kill input for bubbles. It absorbs the memory latency across stalls with a one-entry hold register, and applies EX-stage redirects (taken branches and jumps) with a fixed two-cycle penalty.

## Interface
- RESET_PC, 32'h01000000, first fetch address after reset
- NOP_INSTR, 32'h00000013, value on instr_out whenever kill_out=1
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit freeze; holds the fetch state and the presented pair
- redirect  in  1  EX has resolved a taken branch or jump this cycle
- redirect_pc  in  32  target PC; bits [1:0] are ignored and treated as 0
- imem_addr  out  32  instruction memory read address; equals the pc_req register
- imem_rdata  in  32  data for the imem_addr presented on the previous clock edge
- pc_out  out  32  PC of the instruction presented to IF/ID
- instr_out  out  32  instruction presented to IF/ID
- kill_out  out  1  drives IF/ID kill; 1 means insert a bubble
- valid_out  out  1  equals ~kill_out

## Operation
- State registers:
  - pc_req: address being requested.
  - pc_resp: address whose data is on imem_rdata, or in hold.
  - resp_valid: marks pc_resp data as correct-path.
  - hold_instr / hold_valid: capture of imem_rdata during a stall.
- Per-edge update priority is reset > redirect > stall > advance.
- Reset: pc_req←RESET_PC, pc_resp←0, resp_valid←0, hold_valid←0. During the reset cycle, kill_out is forced to 1.
- Redirect (ignores stall): pc_req←{redirect_pc[31:2],2'b00}, resp_valid←0, hold_valid←0. kill_out=1 combinationally in the redirect cycle.
- Stall without redirect:
  - pc_req, pc_resp and resp_valid are held.
  - If resp_valid=1 and hold_valid=0: hold_instr←imem_rdata, hold_valid←1.
  - If resp_valid=0, the hold register is untouched.
- Advance (no stall, no redirect): pc_resp←pc_req, pc_req←pc_req+4 modulo 2^32, resp_valid←1, hold_valid←0.
- Outputs, all combinational from state and inputs:
  - kill_out = reset | redirect | ~resp_valid.
  - pc_out = pc_resp.
  - instr_out = NOP_INSTR if kill_out; otherwise hold_instr if hold_valid; otherwise imem_rdata.
- Stall while resp_valid=0 keeps kill_out=1; the bubble persists until the stall releases.

## Timing
- Reset values, observed after the reset edge with reset low:
  - imem_addr = RESET_PC.
  - kill_out = 1, valid_out = 0, instr_out = NOP_INSTR.
  - pc_out = 0.
- First valid pair: {RESET_PC, mem[RESET_PC]} appears in the second cycle after reset deasserts. Then one instruction per cycle while unstalled.
- Stall entry at cycle N, presenting {A, mem[A]}:
  - Cycle N captures mem[A] into hold.
  - Cycles N+1 onward present {A, mem[A]} from hold; imem_addr stays at A+4.
- Stall release: in the first unstalled cycle, hold is still presented. The next cycle presents {A+4, mem[A+4]} directly from memory. No instruction is lost or duplicated.
- Redirect penalty:
  - Redirect cycle R: kill_out=1.
  - Cycle R+1: kill_out=1 (stale data is discarded).
  - Cycle R+2: presents {T, mem[T]}, where T is the redirect target.
- Redirect in the same cycle as stall: the redirect wins and hold is discarded.
- Redirect during the bubble after a previous redirect: the newest target wins, and the penalty restarts from that cycle.
- Reset asserted mid-stream: takes effect on the next edge regardless of stall or redirect.
- PC increment wraps: 32'hFFFFFFFC + 4 gives 32'h00000000, with no flag raised.

## Test plan
- Reset, then free run with mem[a]=a^32'hA5A5A5A5 → kill_out=1 for 2 cycles after reset, then pc_out 0x01000000, 0x01000004, 0x01000008 on consecutive cycles with matching instr_out.
- Stall for 3 cycles while pc_out=0x01000008 → pc_out and instr_out held for 4 cycles total, imem_addr=0x0100000C throughout; after release the next pair is 0x0100000C.
- Redirect to 0x02000002 while pc_out=0x01000010 → 2 cycles with kill_out=1 and instr_out=0x00000013, then pc_out=0x02000000.
- Redirect and stall asserted together, then stall held 2 more cycles → redirect taken; kill_out=1 until the stall drops; first valid pc_out=target with no stale hold data.
- Redirect to 0xFFFFFFF8 → valid pairs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert reset for 1 cycle during a stall holding hold_valid=1 → next cycle imem_addr=0x01000000 and kill_out=1; hold contents never appear on instr_out.
